synch_down_counter: RTL and testbench

Synchronous, loadable, parameterised down-counter with terminal-count pulse and optional auto-reload. It is the counting-down counterpart to the ripple up-counter block. It is a fully synchronous timer/divider: the counter is loaded with a value, counts down on enabled cycles, and flags reaching zero. A surrounding design uses it as a programmable interval timer or as a modulo-(N+1) clock-enable divider.

---
 rtl/synch_down_counter_pkg.sv | 9 +
 rtl/synch_down_counter.sv | 76 +++++++
 tb/tb_synch_down_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/synch_down_counter_pkg.sv
// Shared state encoding for the loadable down-counter FSM.
package synch_down_counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/synch_down_counter.sv
// Loadable down-counter with a one-cycle terminal-count pulse and optional
// auto-reload of the last loaded value. All outputs come straight from flops.
module synch_down_counter
  import synch_down_counter_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] load_val,
  input  logic            en,
  input  logic            auto_reload,
  output logic [SIZE-1:0] Q,
  output logic            tc,
  output logic            busy
);

  localparam logic [SIZE-1:0] ZERO = '0;
  localparam logic [SIZE-1:0] ONE  = SIZE'(1);

  state_e          state_q, state_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] rld_q, rld_d;
  logic            tc_q, tc_d;

  // NOTE: every signal gets a default before the branches so no path leaves
  // one unassigned; otherwise synthesis infers a latch to hold it.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (load) begin
      // Load wins over counting, which also swallows a tc due on this edge.
      q_d     = load_val;
      rld_d   = load_val;
      state_d = (load_val != ZERO) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (q_q > ONE) begin
        q_d = q_q - ONE;
      end else if (q_q == ONE) begin
        q_d  = ZERO;
        tc_d = 1'b1;
      end else if (auto_reload) begin
        q_d = rld_q;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: reset is sampled on the clock edge here, so rst is simply the
  // highest-priority branch of the clocked block rather than in its sensitivity list.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= ZERO;
      rld_q   <= ZERO;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  assign Q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_synch_down_counter.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor
// pops and compares them one cycle at a time.
module tb_synch_down_counter;

  localparam int SIZE = 4;

  typedef struct packed {
    logic [SIZE-1:0] q;
    logic            tc;
    logic            busy;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [SIZE-1:0] load_val;
  logic            en;
  logic            auto_reload;
  logic [SIZE-1:0] Q;
  logic            tc;
  logic            busy;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  synch_down_counter #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .auto_reload(auto_reload),
    .Q          (Q),
    .tc         (tc),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got Q=%0d tc=%0b busy=%0b, expected Q=%0d tc=%0b busy=%0b",
               nm, act.q, act.tc, act.busy, exp.q, exp.tc, exp.busy);
    end
  endtask

  // Drive one edge worth of inputs and queue the outputs expected after it.
  task automatic step(input logic r, input logic l, input int lv, input logic e,
                      input logic ar, input int eq, input logic etc, input logic eb,
                      input string nm);
    exp_t x;
    @(negedge clk);
    rst         = r;
    load        = l;
    load_val    = SIZE'(lv);
    en          = e;
    auto_reload = ar;
    x.q    = SIZE'(eq);
    x.tc   = etc;
    x.busy = eb;
    exp_q.push_back(x);
    name_q.push_back(nm);
  endtask

  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, exp_t'{Q, tc, busy}, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; auto_reload = 1'b0;

    // Reset dominates a concurrent load.
    step(1, 1, 9, 1, 0, 0, 0, 0, "reset_a");
    step(1, 1, 9, 1, 0, 0, 0, 0, "reset_b");
    step(0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");
    step(0, 0, 0, 1, 0, 0, 0, 0, "idle_ignores_en");

    // One-shot from 5.
    step(0, 1, 5, 1, 0, 5, 0, 1, "oneshot_load");
    for (int v = 4; v >= 1; v--) step(0, 0, 0, 1, 0, v, 0, 1, "oneshot_dec");
    step(0, 0, 0, 1, 0, 0, 1, 1, "oneshot_tc");
    step(0, 0, 0, 1, 0, 0, 0, 0, "oneshot_stop");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0, 0, 0, 0, "oneshot_hold");

    // Auto-reload of 3: period of 4 cycles, three periods.
    step(0, 1, 3, 1, 1, 3, 0, 1, "ar_load");
    for (int p = 0; p < 3; p++) begin
      step(0, 0, 0, 1, 1, 2, 0, 1, "ar_2");
      step(0, 0, 0, 1, 1, 1, 0, 1, "ar_1");
      step(0, 0, 0, 1, 1, 0, 1, 1, "ar_tc");
      step(0, 0, 0, 1, 1, 3, 0, 1, "ar_reload");
    end

    // Enable gating from 4 with alternating en.
    step(0, 1, 4, 1, 0, 4, 0, 1, "gate_load");
    step(0, 0, 0, 1, 0, 3, 0, 1, "gate_en1_3");
    step(0, 0, 0, 0, 0, 3, 0, 1, "gate_en0_3");
    step(0, 0, 0, 1, 0, 2, 0, 1, "gate_en1_2");
    step(0, 0, 0, 0, 0, 2, 0, 1, "gate_en0_2");
    step(0, 0, 0, 1, 0, 1, 0, 1, "gate_en1_1");
    step(0, 0, 0, 0, 0, 1, 0, 1, "gate_en0_1");
    step(0, 0, 0, 1, 0, 0, 1, 1, "gate_tc");
    step(0, 0, 0, 0, 0, 0, 0, 1, "gate_tc_drop");
    step(0, 0, 0, 1, 0, 0, 0, 0, "gate_stop");

    // Load at Q=1 suppresses tc; load of 0 from RUN goes idle silently.
    step(0, 1, 2, 1, 0, 2, 0, 1, "coll_load2");
    step(0, 0, 0, 1, 0, 1, 0, 1, "coll_q1");
    step(0, 1, 7, 1, 0, 7, 0, 1, "coll_reload7");
    step(0, 0, 0, 1, 0, 6, 0, 1, "coll_dec");
    step(0, 1, 0, 1, 0, 0, 0, 0, "coll_load0");
    step(0, 0, 0, 1, 0, 0, 0, 0, "coll_idle");

    // auto_reload is sampled when Q=0 is consumed, not at load.
    step(0, 1, 2, 1, 0, 2, 0, 1, "late_ar_load");
    step(0, 0, 0, 1, 0, 1, 0, 1, "late_ar_1");
    step(0, 0, 0, 1, 0, 0, 1, 1, "late_ar_tc");
    step(0, 0, 0, 1, 1, 2, 0, 1, "late_ar_reload");

    // Max value, reset mid-count, then a full count with no wrap.
    step(0, 1, 15, 1, 0, 15, 0, 1, "max_load");
    for (int v = 14; v >= 6; v--) step(0, 0, 0, 1, 0, v, 0, 1, "max_dec");
    step(1, 0, 0, 1, 0, 0, 0, 0, "mid_reset");
    step(0, 0, 0, 1, 0, 0, 0, 0, "post_reset_idle");
    step(0, 1, 15, 1, 0, 15, 0, 1, "full_load");
    for (int v = 14; v >= 1; v--) step(0, 0, 0, 1, 0, v, 0, 1, "full_dec");
    step(0, 0, 0, 1, 0, 0, 1, 1, "full_tc");
    step(0, 0, 0, 1, 0, 0, 0, 0, "full_stop");
    step(0, 0, 0, 1, 0, 0, 0, 0, "full_no_wrap");

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
